fetch_pc_predictor: RTL and testbench

//  Fetch-stage PC generator that owns the PC register and predicts the next fetch address.

---
 rtl/fetch_pc_predictor_pkg.sv | 26 ++
 rtl/fetch_btb.sv | 74 +++++++
 rtl/fetch_pc_predictor.sv | 80 ++++++++
 tb/tb_fetch_pc_predictor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_predictor_pkg.sv
// Shared fetch-stage constants and the 2-bit branch
// counter update used by the BTB.
package fetch_pc_predictor_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int unsigned PC_STEP = 4;

  function automatic logic [1:0] ctr_train(
    input logic [1:0] c,
    input logic       taken
  );
    logic [1:0] n;
    n = c;
    unique case (1'b1)
      taken && (c != CTR_ST):   n = c + 2'd1;
      !taken && (c != CTR_SNT): n = c - 2'd1;
      default:                  n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit counters:
// one combinational lookup port and one train/allocate port.
module fetch_btb
  import fetch_pc_predictor_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_hit_o,
  output logic            rd_taken_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic            wr_taken_i,
  input  logic            wr_is_jal_i,
  input  logic [XLEN-1:0] wr_target_i
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [BTB_ENTRIES];
  logic [1:0]       ctr_q    [BTB_ENTRIES];
  logic             jal_q    [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]  target_q [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             unused_pc;

  assign rd_idx = rd_pc_i[IDX_W+1:2];
  assign rd_tag = rd_pc_i[XLEN-1:IDX_W+2];
  assign wr_idx = wr_pc_i[IDX_W+1:2];
  assign wr_tag = wr_pc_i[XLEN-1:IDX_W+2];
  assign unused_pc = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken_o  = rd_hit_o && (jal_q[rd_idx] || ctr_q[rd_idx][1]);
  assign rd_target_o = target_q[rd_idx];
  assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (wr_en_i) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_train(ctr_q[wr_idx], wr_taken_i);
      end else if (wr_taken_i) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= CTR_WT;
      end
    end
  end

  // A taken outcome rewrites tag/target/kind on both hit and allocate.
  always_ff @(posedge clk) begin
    if (rst && wr_en_i && wr_taken_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target_i;
      jal_q[wr_idx]    <= wr_is_jal_i;
    end
  end

endmodule

// File: rtl/fetch_pc_predictor.sv
// Fetch PC register with BTB prediction, stall hold and
// mispredict redirect from execute.
module fetch_pc_predictor
  import fetch_pc_predictor_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_jal,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] ex_seq;
  logic            btb_hit;
  logic            btb_taken;
  logic [XLEN-1:0] btb_target;

  fetch_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .rd_pc_i     (pc_q),
    .rd_hit_o    (btb_hit),
    .rd_taken_o  (btb_taken),
    .rd_target_o (btb_target),
    .wr_en_i     (ex_valid),
    .wr_pc_i     (ex_pc),
    .wr_taken_i  (ex_taken),
    .wr_is_jal_i (ex_is_jal),
    .wr_target_i (ex_target)
  );

  assign pc_seq      = pc_q + XLEN'(PC_STEP);
  assign ex_seq      = ex_pc + XLEN'(PC_STEP);
  assign pc          = pc_q;
  assign pred_taken  = btb_taken;
  assign pred_target = btb_hit ? btb_target : pc_seq;

  assign flush = rst && ex_valid &&
                 ((ex_pred_taken != ex_taken) ||
                  (ex_taken && (ex_pred_target != ex_target)));

  // Redirect wins over stall so a killed path never stays held.
  always_comb begin
    pc_d = pc_seq;
    priority case (1'b1)
      flush:      pc_d = ex_taken ? ex_target : ex_seq;
      stall:      pc_d = pc_q;
      pred_taken: pc_d = pred_target;
      default:    pc_d = pc_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Self-checking bench: vector table, directed corner sequences
// and random traffic against a behavioural predictor model.
module tb_fetch_pc_predictor;

  localparam int          N   = 16;
  localparam logic [31:0] RPC = 32'h1000;

  logic        clk, rst, stall;
  logic [31:0] pc, pred_target;
  logic        pred_taken, flush;
  logic        ex_valid, ex_is_jal, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;

  fetch_pc_predictor #(
    .XLEN        (32),
    .BTB_ENTRIES (N),
    .RESET_PC    (RPC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_jal      (ex_is_jal),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_pc;
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  bit          m_jal   [N];
  int          m_ctr   [N];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] a);
    return a / (4 * N);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
  endfunction

  function automatic bit m_ptk(input logic [31:0] a);
    return m_hit(a) && (m_jal[m_idx(a)] || m_ctr[m_idx(a)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptg(input logic [31:0] a);
    return m_hit(a) ? m_tgt[m_idx(a)] : a + 32'd4;
  endfunction

  function automatic bit m_flush();
    if (!rst || !ex_valid) return 1'b0;
    if (ex_pred_taken != ex_taken) return 1'b1;
    return ex_taken && (ex_pred_target != ex_target);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  // Check this cycle's outputs, then advance model and DUT by one edge.
  task automatic tick();
    bit          f;
    int          i;
    logic [31:0] npc;
    #1;
    chk("pc", pc, m_pc);
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_ptk(m_pc)});
    chk("pred_target", pred_target, m_ptg(m_pc));
    f = m_flush();
    chk("flush", {31'd0, flush}, {31'd0, f});
    if (!rst)              npc = RPC;
    else if (f)            npc = ex_taken ? ex_target : ex_pc + 32'd4;
    else if (stall)        npc = m_pc;
    else if (m_ptk(m_pc))  npc = m_ptg(m_pc);
    else                   npc = m_pc + 32'd4;
    if (!rst) begin
      m_clear();
    end else if (ex_valid) begin
      i = m_idx(ex_pc);
      if (m_hit(ex_pc)) begin
        if (ex_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = ex_target;
          m_jal[i] = ex_is_jal;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ex_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(ex_pc);
        m_tgt[i]   = ex_target;
        m_jal[i]   = ex_is_jal;
        m_ctr[i]   = 2;
      end
    end
    @(posedge clk);
    #1;
    m_pc = npc;
  endtask

  task automatic ex(input logic [31:0] a, input bit jal, input bit tk,
                    input logic [31:0] tg, input bit pt,
                    input logic [31:0] ptg, input bit xf);
    ex_valid       = 1'b1;
    ex_pc          = a;
    ex_is_jal      = jal;
    ex_taken       = tk;
    ex_target      = tg;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
    #1;
    chk("ex_flush", {31'd0, flush}, {31'd0, xf});
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic goto(input logic [31:0] a, input bit xpt);
    ex(a - 32'd4, 1'b0, 1'b0, 32'd0, 1'b1, a, 1'b1);
    chk("goto_pc", pc, a);
    chk("goto_pred", {31'd0, pred_taken}, {31'd0, xpt});
  endtask

  typedef struct {
    bit          ev;
    logic [31:0] epc;
    bit          tk;
    logic [31:0] etg;
    bit          ept;
    logic [31:0] eptg;
    logic [31:0] x_pc;
    bit          x_pt;
    logic [31:0] x_ptg;
    bit          x_fl;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] pool [8];

  initial begin
    tbl[0] = '{0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h1000, 0, 32'h1004, 0};
    tbl[1] = '{0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h1004, 0, 32'h1008, 0};
    tbl[2] = '{1, 32'h1008, 1, 32'h1100, 0, 32'h0,    32'h1008, 0, 32'h100C, 1};
    tbl[3] = '{1, 32'h1004, 0, 32'h0,    1, 32'h1008, 32'h1100, 0, 32'h1104, 1};
    tbl[4] = '{0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h1008, 1, 32'h1100, 0};
    tbl[5] = '{0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h1100, 0, 32'h1104, 0};
    pool = '{32'h1000, 32'h1004, 32'h1008, 32'h1048,
             32'h2000, 32'h4000, 32'hFFFFFFFC, 32'h20};

    rst = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_is_jal = 1'b0;
    ex_taken = 1'b0; ex_pred_taken = 1'b0;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0;
    @(posedge clk);
    #1;
    m_pc = RPC;
    m_clear();

    // Reset held with a mispredicting ex: flush must stay low.
    ex_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h5000;
    #1;
    chk("rst_flush", {31'd0, flush}, 32'd0);
    tick();
    ex_valid = 1'b0; ex_taken = 1'b0;
    rst = 1'b1;

    for (int k = 0; k < 6; k++) begin
      ex_valid       = tbl[k].ev;
      ex_pc          = tbl[k].epc;
      ex_is_jal      = 1'b0;
      ex_taken       = tbl[k].tk;
      ex_target      = tbl[k].etg;
      ex_pred_taken  = tbl[k].ept;
      ex_pred_target = tbl[k].eptg;
      #1;
      chk($sformatf("tbl%0d_pc", k), pc, tbl[k].x_pc);
      chk($sformatf("tbl%0d_pt", k), {31'd0, pred_taken}, {31'd0, tbl[k].x_pt});
      chk($sformatf("tbl%0d_ptg", k), pred_target, tbl[k].x_ptg);
      chk($sformatf("tbl%0d_fl", k), {31'd0, flush}, {31'd0, tbl[k].x_fl});
      tick();
    end
    ex_valid = 1'b0;

    // Counter walk on 1008 (starts weakly taken).
    ex(32'h1008, 0, 0, 32'h0, 1, 32'h1100, 1);
    ex(32'h1008, 0, 0, 32'h0, 0, 32'h0, 0);
    goto(32'h1008, 1'b0);
    ex(32'h1008, 0, 1, 32'h1100, 0, 32'h0, 1);
    goto(32'h1008, 1'b0);
    ex(32'h1008, 0, 1, 32'h1100, 0, 32'h0, 1);
    ex(32'h1008, 0, 1, 32'h1100, 1, 32'h1100, 0);
    ex(32'h1008, 0, 1, 32'h1100, 1, 32'h1100, 0);
    ex(32'h1008, 0, 0, 32'h0, 1, 32'h1100, 1);
    goto(32'h1008, 1'b1);
    chk("sat_ptg", pred_target, 32'h1100);

    // Redirect beats stall, then stall holds.
    stall = 1'b1;
    ex(32'h20, 0, 1, 32'h4000, 0, 32'h0, 1);
    chk("stall_redirect", pc, 32'h4000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", pc, 32'h4000);
    end
    stall = 1'b0;

    // JAL target check.
    ex(32'h2000, 1, 1, 32'h3000, 0, 32'h0, 1);
    ex(32'h2000, 1, 1, 32'h3000, 1, 32'h3000, 0);
    ex(32'h2000, 1, 1, 32'h3000, 1, 32'h3004, 1);
    chk("jal_redirect", pc, 32'h3000);

    // Aliasing eviction and PC wrap.
    ex(32'h1048, 0, 1, 32'h5000, 0, 32'h0, 1);
    goto(32'h1008, 1'b0);
    goto(32'h1048, 1'b1);
    chk("alias_ptg", pred_target, 32'h5000);
    goto(32'hFFFFFFFC, 1'b0);
    tick();
    chk("wrap_pc", pc, 32'h0);

    for (int k = 0; k < 400; k++) begin
      rst            = ($urandom % 60) != 0;
      stall          = ($urandom % 4) == 0;
      ex_valid       = $urandom % 2;
      ex_pc          = pool[$urandom % 8];
      ex_is_jal      = ($urandom % 4) == 0;
      ex_taken       = ex_is_jal ? 1'b1 : 1'($urandom % 2);
      ex_target      = pool[$urandom % 8];
      ex_pred_taken  = $urandom % 2;
      ex_pred_target = ($urandom % 2) ? ex_target : pool[$urandom % 8];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
